// File: rtl/multicycle_control_if.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_control_if
//  Description : Bundle of signals between the multicycle main controller and
//                the RV64 datapath/memory.
//                  master : controller side (takes opcode/flags, drives strobes)
//                  slave  : datapath side (drives opcode/flags, takes strobes)
//                Ports carried:
//                  Opc, zero, mem_ready            -> controller
//                  PCWrite, Branch, PCSource, IorD,
//                  MemRead, MemWrite, IRWrite,
//                  RegWrite, MemToReg, ALUsrcA,
//                  ALUsrcB, AluOp, illegal, state,
//                  instret                         <- controller
//  Revision    : 1.0  initial release
// ============================================================================
interface multicycle_control_if #(
  parameter int OPC_W = 7,
  parameter int CNT_W = 32
);
  logic [OPC_W-1:0] Opc;
  logic             zero;
  logic             mem_ready;

  logic             PCWrite;
  logic             Branch;
  logic             PCSource;
  logic             IorD;
  logic             MemRead;
  logic             MemWrite;
  logic             IRWrite;
  logic             RegWrite;
  logic [1:0]       MemToReg;
  logic             ALUsrcA;
  logic [1:0]       ALUsrcB;
  logic [1:0]       AluOp;
  logic             illegal;
  logic [3:0]       state;
  logic [CNT_W-1:0] instret;

  modport master (
    input  Opc, zero, mem_ready,
    output PCWrite, Branch, PCSource, IorD, MemRead, MemWrite, IRWrite,
           RegWrite, MemToReg, ALUsrcA, ALUsrcB, AluOp, illegal, state, instret
  );

  modport slave (
    output Opc, zero, mem_ready,
    input  PCWrite, Branch, PCSource, IorD, MemRead, MemWrite, IRWrite,
           RegWrite, MemToReg, ALUsrcA, ALUsrcB, AluOp, illegal, state, instret
  );
endinterface
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_control
//  Description : Sequential main controller for the multicycle RV64 datapath.
//                Steps each instruction through FETCH/DECODE/EXEC/MEM/WB,
//                waits on mem_ready for memory accesses, traps on undecodable
//                opcodes and counts retired instructions.
//                Ports:
//                  clk  : clock, all state changes on the rising edge
//                  rst  : synchronous active-high reset
//                  bus  : multicycle_control_if.master (opcode, zero,
//                         mem_ready in; datapath strobes, illegal, state,
//                         instret out)
//  Revision    : 1.0  initial release
// ============================================================================
module multicycle_control #(
  parameter int OPC_W    = 7,
  parameter int EN_OPIMM = 1,
  parameter int EN_JAL   = 1,
  parameter int CNT_W    = 32
) (
  input  wire logic              clk,
  input  wire logic              rst,
  multicycle_control_if.master   bus
);

  localparam logic [OPC_W-1:0] c_opcRType  = OPC_W'(7'b0110011);
  localparam logic [OPC_W-1:0] c_opcOpImm  = OPC_W'(7'b0010011);
  localparam logic [OPC_W-1:0] c_opcLoad   = OPC_W'(7'b0000011);
  localparam logic [OPC_W-1:0] c_opcStore  = OPC_W'(7'b0100011);
  localparam logic [OPC_W-1:0] c_opcBranch = OPC_W'(7'b1100011);
  localparam logic [OPC_W-1:0] c_opcJal    = OPC_W'(7'b1101111);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_MEM_ADDR = 4'd4,
    S_MEM_RD   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_WB_ALU   = 4'd7,
    S_WB_MEM   = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_TRAP     = 4'd11
  } state_t;

  // Per-state control word. fetchStrobe marks FETCH so that IRWrite/PCWrite
  // can follow mem_ready there without the register waiting a cycle.
  typedef struct packed {
    logic       pcWrite;
    logic       branch;
    logic       pcSource;
    logic       iorD;
    logic       memRead;
    logic       memWrite;
    logic       fetchStrobe;
    logic       regWrite;
    logic [1:0] memToReg;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] aluOp;
    logic       illegal;
  } ctrl_t;

  state_t           r_state;
  ctrl_t            r_ctrl;
  logic [CNT_W-1:0] r_instret;
  state_t           w_nextState;
  logic             w_retire;
  logic             w_unused;

  // Moore control word for a given state; everything not set stays 0.
  function automatic ctrl_t decodeOutputs(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.memRead     = 1'b1;
        c.aluSrcB     = 2'b01;
        c.fetchStrobe = 1'b1;
      end
      S_DECODE: begin
        c.aluSrcB = 2'b10;
      end
      S_EXEC_R: begin
        c.aluSrcA = 1'b1;
        c.aluOp   = 2'b10;
      end
      S_EXEC_I: begin
        c.aluSrcA = 1'b1;
        c.aluSrcB = 2'b10;
        c.aluOp   = 2'b11;
      end
      S_MEM_ADDR: begin
        c.aluSrcA = 1'b1;
        c.aluSrcB = 2'b10;
      end
      S_MEM_RD: begin
        c.memRead = 1'b1;
        c.iorD    = 1'b1;
      end
      S_MEM_WR: begin
        c.memWrite = 1'b1;
        c.iorD     = 1'b1;
      end
      S_WB_ALU: begin
        c.regWrite = 1'b1;
      end
      S_WB_MEM: begin
        c.regWrite = 1'b1;
        c.memToReg = 2'b01;
      end
      S_BRANCH: begin
        c.aluSrcA  = 1'b1;
        c.aluOp    = 2'b01;
        c.branch   = 1'b1;
        c.pcSource = 1'b1;
      end
      S_JAL: begin
        // PC was already advanced to PC+4 in FETCH, so it is the link value.
        c.regWrite = 1'b1;
        c.memToReg = 2'b10;
        c.pcWrite  = 1'b1;
        c.pcSource = 1'b1;
      end
      default: begin
        c.illegal = 1'b1;
      end
    endcase
    return c;
  endfunction

  function automatic state_t nextStateOf(input state_t s,
                                         input logic [OPC_W-1:0] opc,
                                         input logic ready);
    state_t n;
    n = S_TRAP;
    case (s)
      S_FETCH:  n = ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (opc == c_opcRType)                      n = S_EXEC_R;
        else if (opc == c_opcOpImm && EN_OPIMM != 0) n = S_EXEC_I;
        else if (opc == c_opcLoad || opc == c_opcStore) n = S_MEM_ADDR;
        else if (opc == c_opcBranch)                n = S_BRANCH;
        else if (opc == c_opcJal && EN_JAL != 0)    n = S_JAL;
        else                                        n = S_TRAP;
      end
      S_EXEC_R:   n = S_WB_ALU;
      S_EXEC_I:   n = S_WB_ALU;
      S_MEM_ADDR: n = (opc == c_opcLoad) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   n = ready ? S_WB_MEM : S_MEM_RD;
      S_MEM_WR:   n = ready ? S_FETCH : S_MEM_WR;
      S_WB_ALU:   n = S_FETCH;
      S_WB_MEM:   n = S_FETCH;
      S_BRANCH:   n = S_FETCH;
      S_JAL:      n = S_FETCH;
      // TRAP is absorbing; the unused encodings also collapse into it.
      default:    n = S_TRAP;
    endcase
    return n;
  endfunction

  assign w_nextState = nextStateOf(r_state, bus.Opc, bus.mem_ready);
  assign w_retire    = (w_nextState == S_FETCH) && (r_state != S_FETCH);

  // The control word is registered from the next state so that every output
  // is a flop output that matches the state it accompanies.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_FETCH;
      r_ctrl    <= decodeOutputs(S_FETCH);
      r_instret <= '0;
    end else begin
      r_state <= w_nextState;
      r_ctrl  <= decodeOutputs(w_nextState);
      if (w_retire) begin
        r_instret <= r_instret + CNT_W'(1);
      end
    end
  end

  // Architectural-state strobes are masked by rst combinationally so that a
  // store or write-back in flight is cancelled in the cycle reset rises.
  assign bus.PCWrite  = ~rst & (r_ctrl.pcWrite | (r_ctrl.fetchStrobe & bus.mem_ready));
  assign bus.IRWrite  = ~rst & r_ctrl.fetchStrobe & bus.mem_ready;
  assign bus.Branch   = ~rst & r_ctrl.branch;
  assign bus.MemWrite = ~rst & r_ctrl.memWrite;
  assign bus.RegWrite = ~rst & r_ctrl.regWrite;

  assign bus.PCSource = r_ctrl.pcSource;
  assign bus.IorD     = r_ctrl.iorD;
  assign bus.MemRead  = r_ctrl.memRead;
  assign bus.MemToReg = r_ctrl.memToReg;
  assign bus.ALUsrcA  = r_ctrl.aluSrcA;
  assign bus.ALUsrcB  = r_ctrl.aluSrcB;
  assign bus.AluOp    = r_ctrl.aluOp;
  assign bus.illegal  = r_ctrl.illegal;
  assign bus.state    = r_state;
  assign bus.instret  = r_instret;

  // The zero flag is consumed by the datapath's PC-load gating, not here.
  assign w_unused = bus.zero;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multicycle_control
//  Description : Self-checking bench for multicycle_control. Three instances
//                (full decode / no OP-IMM with 4-bit counter / no JAL) share
//                the stimulus; the selected one is compared each cycle against
//                an instruction-level model that expands every opcode into
//                its expected state trace.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_multicycle_control;

  localparam logic [6:0] c_R   = 7'b0110011;
  localparam logic [6:0] c_I   = 7'b0010011;
  localparam logic [6:0] c_LD  = 7'b0000011;
  localparam logic [6:0] c_SD  = 7'b0100011;
  localparam logic [6:0] c_BEQ = 7'b1100011;
  localparam logic [6:0] c_JAL = 7'b1101111;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] opc;
  logic       zero;
  logic       memReady;

  always #5 clk = ~clk;

  multicycle_control_if #(.OPC_W(7), .CNT_W(32)) if0 ();
  multicycle_control_if #(.OPC_W(7), .CNT_W(4))  if1 ();
  multicycle_control_if #(.OPC_W(7), .CNT_W(32)) if2 ();

  assign if0.Opc = opc;  assign if0.zero = zero;  assign if0.mem_ready = memReady;
  assign if1.Opc = opc;  assign if1.zero = zero;  assign if1.mem_ready = memReady;
  assign if2.Opc = opc;  assign if2.zero = zero;  assign if2.mem_ready = memReady;

  multicycle_control #(.OPC_W(7), .EN_OPIMM(1), .EN_JAL(1), .CNT_W(32)) dut0 (
    .clk(clk), .rst(rst), .bus(if0.master));
  multicycle_control #(.OPC_W(7), .EN_OPIMM(0), .EN_JAL(1), .CNT_W(4)) dut1 (
    .clk(clk), .rst(rst), .bus(if1.master));
  multicycle_control #(.OPC_W(7), .EN_OPIMM(1), .EN_JAL(0), .CNT_W(32)) dut2 (
    .clk(clk), .rst(rst), .bus(if2.master));

  // {PCWrite,Branch,PCSource,IorD,MemRead,MemWrite,IRWrite,RegWrite,
  //  MemToReg,ALUsrcA,ALUsrcB,AluOp,illegal}
  wire [15:0] pk0 = {if0.PCWrite, if0.Branch, if0.PCSource, if0.IorD, if0.MemRead,
                     if0.MemWrite, if0.IRWrite, if0.RegWrite, if0.MemToReg,
                     if0.ALUsrcA, if0.ALUsrcB, if0.AluOp, if0.illegal};
  wire [15:0] pk1 = {if1.PCWrite, if1.Branch, if1.PCSource, if1.IorD, if1.MemRead,
                     if1.MemWrite, if1.IRWrite, if1.RegWrite, if1.MemToReg,
                     if1.ALUsrcA, if1.ALUsrcB, if1.AluOp, if1.illegal};
  wire [15:0] pk2 = {if2.PCWrite, if2.Branch, if2.PCSource, if2.IorD, if2.MemRead,
                     if2.MemWrite, if2.IRWrite, if2.RegWrite, if2.MemToReg,
                     if2.ALUsrcA, if2.ALUsrcB, if2.AluOp, if2.illegal};

  int          sel;
  bit          enI, enJ;
  logic [3:0]  obsState;
  logic [15:0] obsOut;
  logic [31:0] obsCnt;
  logic [31:0] cntMask;
  longint      expCnt;
  int          passed = 0;
  int          total  = 0;
  int          failed = 0;

  always_comb begin
    obsState = if0.state;
    obsOut   = pk0;
    obsCnt   = if0.instret;
    if (sel == 1) begin
      obsState = if1.state;  obsOut = pk1;  obsCnt = 32'(if1.instret);
    end else if (sel == 2) begin
      obsState = if2.state;  obsOut = pk2;  obsCnt = if2.instret;
    end
  end

  typedef struct { int st; bit rdy; } step_t;
  step_t plan[$];

  // Expected output word for a state number, straight from the state table.
  function automatic logic [15:0] expOut(int st, bit rdy, bit r);
    bit pcw = 0, br = 0, pcs = 0, iord = 0, mr = 0, mw = 0, irw = 0, rw = 0, a = 0, ill = 0;
    bit [1:0] m2r = 0, b = 0, op = 0;
    case (st)
      0:  begin mr = 1; b = 2'b01; irw = rdy; pcw = rdy; end
      1:  begin b = 2'b10; end
      2:  begin a = 1; op = 2'b10; end
      3:  begin a = 1; b = 2'b10; op = 2'b11; end
      4:  begin a = 1; b = 2'b10; end
      5:  begin mr = 1; iord = 1; end
      6:  begin mw = 1; iord = 1; end
      7:  begin rw = 1; end
      8:  begin rw = 1; m2r = 2'b01; end
      9:  begin a = 1; op = 2'b01; br = 1; pcs = 1; end
      10: begin rw = 1; m2r = 2'b10; pcw = 1; pcs = 1; end
      default: begin ill = 1; end
    endcase
    if (r) begin pcw = 0; br = 0; mw = 0; rw = 0; irw = 0; end
    return {pcw, br, pcs, iord, mr, mw, irw, rw, m2r, a, b, op, ill};
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s (dut%0d, t=%0t): observed 0x%0h expected 0x%0h", tag, sel, $time, obs, exp);
    end
  endtask

  task automatic addMem(int st, int waits);
    for (int k = 0; k < waits; k++) plan.push_back('{st, 1'b0});
    plan.push_back('{st, 1'b1});
  endtask

  task automatic addFixed(int st);
    plan.push_back('{st, 1'($urandom % 2)});
  endtask

  // Expand an instruction into the state trace it must produce.
  task automatic buildPlan(logic [6:0] o, int fw, int mw, int hold, output bit retires);
    plan.delete();
    retires = 1'b1;
    addMem(0, fw);
    addFixed(1);
    if (o == c_R) begin addFixed(2); addFixed(7); end
    else if (o == c_I && enI) begin addFixed(3); addFixed(7); end
    else if (o == c_LD) begin addFixed(4); addMem(5, mw); addFixed(8); end
    else if (o == c_SD) begin addFixed(4); addMem(6, mw); end
    else if (o == c_BEQ) addFixed(9);
    else if (o == c_JAL && enJ) addFixed(10);
    else begin
      retires = 1'b0;
      for (int k = 0; k <= hold; k++) addFixed(11);
    end
  endtask

  task automatic runPlan(int nSteps);
    for (int i = 0; i < nSteps && i < plan.size(); i++) begin
      memReady = plan[i].rdy;
      zero     = 1'($urandom % 2);
      @(negedge clk);
      check("state", 32'(obsState), 32'(plan[i].st));
      check("outputs", 32'(obsOut), 32'(expOut(plan[i].st, plan[i].rdy, 1'b0)));
      check("instret", obsCnt, 32'(expCnt) & cntMask);
      @(posedge clk); #1;
    end
  endtask

  task automatic runInstr(logic [6:0] o, int fw, int mw, int hold);
    bit ret;
    opc = o;
    buildPlan(o, fw, mw, hold, ret);
    runPlan(plan.size());
    if (ret) expCnt++;
  endtask

  // Hold rst for ncyc edges; curSt >= 0 checks masking in the first cycle.
  task automatic doReset(int ncyc, int curSt);
    rst      = 1'b1;
    memReady = 1'($urandom % 2);
    @(negedge clk);
    if (curSt >= 0) begin
      check("state@rst", 32'(obsState), 32'(curSt));
      check("masked@rst", 32'(obsOut), 32'(expOut(curSt, memReady, 1'b1)));
    end
    @(posedge clk); #1;
    for (int k = 1; k < ncyc; k++) begin
      @(negedge clk);
      check("state@rst", 32'(obsState), 32'd0);
      check("outputs@rst", 32'(obsOut), 32'(expOut(0, memReady, 1'b1)));
      check("instret@rst", obsCnt, 32'd0);
      @(posedge clk); #1;
    end
    rst    = 1'b0;
    expCnt = 0;
  endtask

  logic [6:0] pool [6];

  initial begin
    pool[0] = c_R;  pool[1] = c_I;  pool[2] = c_LD;
    pool[3] = c_SD; pool[4] = c_BEQ; pool[5] = c_JAL;
    rst = 1'b1; opc = c_R; zero = 1'b0; memReady = 1'b1;
    expCnt = 0;

    // ---------------- full decoder, 32-bit counter ----------------
    sel = 0; enI = 1; enJ = 1; cntMask = 32'hFFFF_FFFF;
    doReset(2, -1);
    runInstr(c_R, 0, 0, 0);
    runInstr(c_LD, 0, 3, 0);
    runInstr(c_BEQ, 0, 0, 0);
    runInstr(c_JAL, 0, 0, 0);
    runInstr(c_SD, 1, 1, 0);
    for (int n = 0; n < 40; n++) begin
      runInstr(pool[$urandom_range(0, 5)], $urandom_range(0, 3), $urandom_range(0, 3), 0);
    end

    // reset while a store waits on memory
    opc = c_SD;
    begin
      bit ret;
      buildPlan(c_SD, 0, 2, 0, ret);
    end
    runPlan(3);
    doReset(1, 6);
    runInstr(c_R, 1, 0, 0);

    // undecodable opcode traps and sticks
    runInstr(7'b1111111, 0, 0, 10);
    doReset(1, 11);
    runInstr(c_I, 0, 0, 0);

    // ---------------- OP-IMM disabled, 4-bit counter ----------------
    sel = 1; enI = 0; enJ = 1; cntMask = 32'h0000_000F;
    doReset(1, -1);
    for (int n = 0; n < 16; n++) runInstr(c_JAL, 0, 0, 0);
    runInstr(c_R, 0, 0, 0);
    runInstr(c_I, 0, 0, 10);
    doReset(1, 11);
    runInstr(c_BEQ, 0, 0, 0);

    // ---------------- JAL disabled ----------------
    sel = 2; enI = 1; enJ = 0; cntMask = 32'hFFFF_FFFF;
    doReset(1, -1);
    for (int n = 0; n < 10; n++) begin
      runInstr(pool[$urandom_range(0, 4)], $urandom_range(0, 2), $urandom_range(0, 2), 0);
    end
    runInstr(c_JAL, 0, 0, 10);
    doReset(1, 11);
    runInstr(c_LD, 2, 1, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
